// File: rtl/hr_pkg.sv
// Shared constants for the hierarchical-ring bridge.
// Flit width mirrors the control word width of the ring.
package hr_pkg;
    localparam int HR_FLIT_W = 144;
    localparam logic [HR_FLIT_W-1:0] HR_IDLE_FLIT = '0;
    localparam int HR_BFIFO_DEPTH = 4;
endpackage

// File: rtl/hr_bridge_fifo_if.sv
// Bridge-to-FIFO port bundle.
// The master is the bridge; the slave is the transfer buffer.
interface hr_bridge_fifo_if
    import hr_pkg::*;
#(
    parameter int WIDTH = HR_FLIT_W,
    parameter int DEPTH = HR_BFIFO_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] flit_i;
    logic             enQ_i;
    logic             deQ_i;
    logic [WIDTH-1:0] head_o;
    logic             bfull_o;
    logic             empty_o;
    logic [AW:0]      count_o;
    logic             ovf_o;
    logic             udf_o;

    modport master (
        output flit_i, enQ_i, deQ_i,
        input  head_o, bfull_o, empty_o,
        input  count_o, ovf_o, udf_o
    );

    modport slave (
        input  flit_i, enQ_i, deQ_i,
        output head_o, bfull_o, empty_o,
        output count_o, ovf_o, udf_o
    );
endinterface

// File: rtl/hr_fifo_mem.sv
// DEPTH x WIDTH register array.
// One synchronous write port, one asynchronous read port.
module hr_fifo_mem
    import hr_pkg::*;
#(
    parameter int WIDTH = HR_FLIT_W,
    parameter int DEPTH = HR_BFIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents are not reset; validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/hr_bridge_fifo.sv
// Per-direction transfer buffer for the hierarchical-ring bridge.
// Pointers, occupancy and sticky error flags live here.
module hr_bridge_fifo
    import hr_pkg::*;
#(
    parameter int WIDTH = HR_FLIT_W,
    parameter int DEPTH = HR_BFIFO_DEPTH
) (
    input logic clk,
    input logic rst,
    hr_bridge_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wp_q, wp_d;
    logic [AW-1:0]    rp_q, rp_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    logic             do_enq;
    logic             do_deq;
    logic [WIDTH-1:0] rdata;

    hr_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (do_enq),
        .waddr_i (wp_q),
        .wdata_i (bus.flit_i),
        .raddr_i (rp_q),
        .rdata_o (rdata)
    );

    // A push into a full buffer is legal when a pop frees the slot.
    always_comb begin
        do_deq = bus.deQ_i && (cnt_q != '0);
        do_enq = bus.enQ_i && ((cnt_q != FULL_CNT) || do_deq);
        wp_d   = wp_q;
        rp_d   = rp_q;
        if (do_enq) begin
            wp_d = wp_q + AW'(1);
        end
        if (do_deq) begin
            rp_d = rp_q + AW'(1);
        end
        cnt_d = cnt_q + {{AW{1'b0}}, do_enq}
                      - {{AW{1'b0}}, do_deq};
        ovf_d = ovf_q || (bus.enQ_i && !do_enq);
        udf_d = udf_q || (bus.deQ_i && (cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign bus.head_o  = (cnt_q == '0) ? WIDTH'(HR_IDLE_FLIT) : rdata;
    assign bus.bfull_o = (cnt_q == FULL_CNT);
    assign bus.empty_o = (cnt_q == '0);
    assign bus.count_o = cnt_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.udf_o   = udf_q;
endmodule
